// File: rtl/cospike_pkg.sv
// cospike_pkg: types and constants shared by the commit-trace arbiter.
//   trace_rec_t - one commit record as stored in a hart FIFO and in the
//                 output register.
//   HARTID_W    - width of the hart ID field presented to the checker.
//   DROP_CNT_W  - width of the saturating dropped-record counter.
package cospike_pkg;

  localparam int HARTID_W   = 64;
  localparam int DROP_CNT_W = 32;

  typedef struct packed {
    logic [63:0] cycle;
    logic        valid;
    logic [63:0] iaddr;
    logic [31:0] insn;
    logic        exception;
    logic        interrupt;
    logic [63:0] cause;
    logic        has_wdata;
    logic [63:0] wdata;
    logic [2:0]  priv;
  } trace_rec_t;

endpackage

// File: rtl/cospike_trace_fifo.sv
// cospike_trace_fifo: per-hart FIFO of trace records with a show-ahead head.
//   clock, reset_n - clock and asynchronous active-low reset (pointers only)
//   push, din      - write din at the tail; caller only pushes when !full or
//                    when popping in the same cycle
//   pop            - drop the head entry; caller only pops when !empty
//   full, empty    - occupancy flags derived from the wrap-bit pointers
//   head           - oldest entry, valid while !empty
module cospike_trace_fifo
  import cospike_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  trace_rec_t din,
  output logic       full,
  output logic       empty,
  output trace_rec_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  trace_rec_t  mem_q [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  // When full with a same-cycle pop, the write lands on the slot being read,
  // which is safe because head is sampled before the edge.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cospike_trace_arbiter.sv
// cospike_trace_arbiter: gathers commit records from NHARTS cores into
// private FIFOs and serialises them, round-robin, onto one valid/ready trace
// port tagged with hart ID and enqueue cycle. Overflow drops and is flagged.
//   clock, reset_n           - clock; async active-low reset, sync release
//   cycle                    - free-running cycle count captured at enqueue
//   in_*                     - per-hart commit fields, hart h in slice h
//   out_valid / out_ready    - output handshake
//   out_hartid, out_cycle    - tags of the presented record
//   out_valid_insn .. out_priv - stored record fields
//   overflow                 - sticky per-hart drop flag
//   drop_count               - saturating total of dropped records
module cospike_trace_arbiter
  import cospike_pkg::*;
#(
  parameter int NHARTS = 2,
  parameter int DEPTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [63:0]           cycle,
  input  logic [NHARTS-1:0]     in_valid,
  input  logic [NHARTS-1:0]     in_exception,
  input  logic [NHARTS-1:0]     in_interrupt,
  input  logic [NHARTS-1:0]     in_has_wdata,
  input  logic [64*NHARTS-1:0]  in_iaddr,
  input  logic [64*NHARTS-1:0]  in_cause,
  input  logic [64*NHARTS-1:0]  in_wdata,
  input  logic [32*NHARTS-1:0]  in_insn,
  input  logic [3*NHARTS-1:0]   in_priv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HARTID_W-1:0]   out_hartid,
  output logic [63:0]           out_cycle,
  output logic                  out_valid_insn,
  output logic                  out_exception,
  output logic                  out_interrupt,
  output logic                  out_has_wdata,
  output logic [63:0]           out_iaddr,
  output logic [63:0]           out_cause,
  output logic [63:0]           out_wdata,
  output logic [31:0]           out_insn,
  output logic [2:0]            out_priv,
  output logic [NHARTS-1:0]     overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int PW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  function automatic logic [DROP_CNT_W-1:0] sat_add(
    input logic [DROP_CNT_W-1:0] base,
    input int unsigned           inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, base} + (DROP_CNT_W+1)'(inc);
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

  // Reset asserts asynchronously everywhere but releases two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [NHARTS-1:0] qual, push, pop, drop, full, empty;
  trace_rec_t        wr_rec [NHARTS];
  trace_rec_t        head   [NHARTS];

  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    assign qual[h]   = in_valid[h] | in_exception[h] | (in_cause[64*h +: 64] != '0);
    // A full FIFO still accepts when it pops this cycle.
    assign push[h]   = qual[h] & (~full[h] | pop[h]);
    assign drop[h]   = qual[h] & full[h] & ~pop[h];
    assign wr_rec[h] = '{cycle:     cycle,
                         valid:     in_valid[h],
                         iaddr:     in_iaddr[64*h +: 64],
                         insn:      in_insn[32*h +: 32],
                         exception: in_exception[h],
                         interrupt: in_interrupt[h],
                         cause:     in_cause[64*h +: 64],
                         has_wdata: in_has_wdata[h],
                         wdata:     in_wdata[64*h +: 64],
                         priv:      in_priv[3*h +: 3]};

    cospike_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (rst_n),
      .push    (push[h]),
      .pop     (pop[h]),
      .din     (wr_rec[h]),
      .full    (full[h]),
      .empty   (empty[h]),
      .head    (head[h])
    );
  end

  logic                  out_valid_q, out_valid_d;
  trace_rec_t            out_rec_q, out_rec_d;
  logic [HARTID_W-1:0]   out_hartid_q, out_hartid_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NHARTS-1:0]     overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic          load, grant_vld;
  logic [PW-1:0] grant_idx;

  // Output register refills when empty or when its record is accepted.
  assign load = ~out_valid_q | out_ready;

  // First non-empty FIFO at or after rr_ptr, wrapping modulo NHARTS.
  always_comb begin
    int            j;
    logic [PW-1:0] jj;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < NHARTS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NHARTS) j = j - NHARTS;
      jj = PW'(j);
      if (!grant_vld && !empty[jj]) begin
        grant_vld = 1'b1;
        grant_idx = jj;
      end
    end
  end

  always_comb begin
    pop          = '0;
    out_valid_d  = out_valid_q;
    out_rec_d    = out_rec_q;
    out_hartid_d = out_hartid_q;
    rr_ptr_d     = rr_ptr_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        pop[grant_idx] = 1'b1;
        out_rec_d      = head[grant_idx];
        out_hartid_d   = HARTID_W'(grant_idx);
        rr_ptr_d       = (grant_idx == PW'(NHARTS-1)) ? '0 : grant_idx + 1'b1;
      end
    end
    overflow_d   = overflow_q | drop;
    drop_count_d = sat_add(drop_count_q, $countones(drop));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_rec_q    <= '0;
      out_hartid_q <= '0;
      rr_ptr_q     <= '0;
      overflow_q   <= '0;
      drop_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_rec_q    <= out_rec_d;
      out_hartid_q <= out_hartid_d;
      rr_ptr_q     <= rr_ptr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_hartid     = out_hartid_q;
  assign out_cycle      = out_rec_q.cycle;
  assign out_valid_insn = out_rec_q.valid;
  assign out_exception  = out_rec_q.exception;
  assign out_interrupt  = out_rec_q.interrupt;
  assign out_has_wdata  = out_rec_q.has_wdata;
  assign out_iaddr      = out_rec_q.iaddr;
  assign out_cause      = out_rec_q.cause;
  assign out_wdata      = out_rec_q.wdata;
  assign out_insn       = out_rec_q.insn;
  assign out_priv       = out_rec_q.priv;
  assign overflow       = overflow_q;
  assign drop_count     = drop_count_q;

endmodule
